// File: rtl/obi_sbr_mem.sv
// obi_sbr_mem: OBI subordinate backed by a word-addressed on-chip memory.
// Pipelined, in-order accesses with up to FIFO_DEPTH outstanding responses,
// R-channel backpressure and error responses for out-of-range/misaligned addresses.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   obi_req_i / obi_gnt_o   A-channel handshake (gnt combinational from state + req)
//   obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i   A-channel payload
//   obi_rvalid_o / obi_rready_i  R-channel handshake
//   obi_rdata_o, obi_err_o  R-channel payload (0 when no response is held)
//   acc_cnt_o               16-bit accepted-transaction counter, only when the
//                           macro OBI_SBR_MEM_ACC_CNT_EN is defined
module obi_sbr_mem #(
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = ADDR_WIDTH'(32'h0000_1000),
    parameter int unsigned                DEPTH      = 256,
    parameter int unsigned                FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0]      ERR_DATA   = DATA_WIDTH'(32'hBADC_AB1E)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      obi_req_i,
    output logic                      obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
    output logic                      obi_rvalid_o,
    input  logic                      obi_rready_i,
    output logic [DATA_WIDTH-1:0]     obi_rdata_o,
    output logic                      obi_err_o
`ifdef OBI_SBR_MEM_ACC_CNT_EN
    ,
    output logic [15:0]               acc_cnt_o
`endif
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    rsp_t                  fifo_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] addr_off;
    logic [IDX_W-1:0]      mem_idx;
    logic                  addr_ok;
    logic                  accept;
    logic                  pop;
    logic                  fifo_empty;
    rsp_t                  rsp_d;

    // Address decode: in range, word aligned, at or above the base
    assign addr_off = obi_addr_i - BASE_ADDR;
    assign addr_ok  = (obi_addr_i >= BASE_ADDR)
                   && ((addr_off >> 2) < ADDR_WIDTH'(DEPTH))
                   && (obi_addr_i[1:0] == 2'b00);
    assign mem_idx  = addr_off[IDX_W+1:2];

    // Handshakes; the outstanding count equals FIFO occupancy
    assign fifo_empty = (cnt_q == '0);
    assign obi_gnt_o  = obi_req_i && (cnt_q < CNT_W'(FIFO_DEPTH)) && !rst_i;
    assign accept     = obi_req_i && obi_gnt_o;
    assign pop        = !fifo_empty && obi_rready_i;

    // Response formed from the memory as it stands before this edge's write
    always_comb begin
        rsp_d = '0;
        if (!addr_ok) begin
            rsp_d.err  = 1'b1;
            rsp_d.data = ERR_DATA;
        end else if (!obi_we_i) begin
            rsp_d.data = mem_q[mem_idx];
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers are reset
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= rsp_d;
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (accept && obi_we_i && addr_ok) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (obi_be_i[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= obi_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // R channel presents the FIFO head, zeroed when nothing is held
    assign obi_rvalid_o = !fifo_empty;
    assign obi_rdata_o  = fifo_empty ? '0   : fifo_q[rd_ptr_q].data;
    assign obi_err_o    = fifo_empty ? 1'b0 : fifo_q[rd_ptr_q].err;

`ifdef OBI_SBR_MEM_ACC_CNT_EN
    logic [15:0] acc_cnt_q;

    // Accepted-transaction counter, wraps naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_cnt_q <= '0;
        end else if (accept) begin
            acc_cnt_q <= acc_cnt_q + 16'd1;
        end
    end

    assign acc_cnt_o = acc_cnt_q;
`endif

endmodule
